// File: rtl/spi_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl_if
// Word-level link between the SPI slave and the RAM command decoder.
//   din      [9:0] command word from the slave ([9:8]=cmd, [7:0]=payload)
//   rx_valid       one-cycle strobe qualifying din
//   dout     [7:0] read data returned to the slave's tx_data
//   tx_valid       dout valid; level, held until the next command strobe
//   cmd_err        one-cycle pulse on a protocol violation
// Modports: master = SPI slave side, slave = RAM controller side.
// ---------------------------------------------------------------------------
interface spi_ram_ctrl_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  cmd_err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output cmd_err
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl
// Single-port RAM with a 2-bit command decoder, sitting behind the SPI slave.
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset (memory contents are kept)
//   bus  - spi_ram_ctrl_if.slave: din/rx_valid in, dout/tx_valid/cmd_err out
// Commands (decoded only while rx_valid=1):
//   00 load write address   01 write data
//   10 load read address    11 read data (needs a preceding 10)
// Parameters:
//   MEM_DEPTH - number of 8-bit words, power of two, <= 256
//   ADDR_SIZE - log2(MEM_DEPTH)
//   AUTO_INC  - nonzero: addresses post-increment after each data access
// ---------------------------------------------------------------------------
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic              clk,
    input  logic              rst,
    spi_ram_ctrl_if.slave     bus
);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] RD_ARMED = 1'b1;

    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(1);

    // Memory array: no reset so it maps onto block RAM.
    logic [7:0] mem [MEM_DEPTH];

    logic [1:0]           cmd;
    logic [7:0]           payload;
    logic                 wr_strobe;
    logic                 rd_strobe;

    logic [ADDR_SIZE-1:0] wr_addr_reg, wr_addr_next;
    logic [ADDR_SIZE-1:0] rd_addr_reg, rd_addr_next;
    logic                 wa_ok_reg, wa_ok_next;
    logic [0:0]           state_reg, state_next;
    logic                 tx_valid_reg, tx_valid_next;
    logic                 cmd_err_reg, cmd_err_next;
    logic                 dout_loaded_reg, dout_loaded_next;
    logic [7:0]           rd_data_reg;

    assign cmd     = bus.din[9:8];
    assign payload = bus.din[7:0];

    // Accepted data accesses. A rejected write/read touches neither the RAM
    // nor the address counters.
    assign wr_strobe = bus.rx_valid && (cmd == CMD_WR_DATA) && wa_ok_reg;
    assign rd_strobe = bus.rx_valid && (cmd == CMD_RD_DATA) && (state_reg == RD_ARMED);

    always_comb begin
        wr_addr_next     = wr_addr_reg;
        rd_addr_next     = rd_addr_reg;
        wa_ok_next       = wa_ok_reg;
        state_next       = state_reg;
        tx_valid_next    = tx_valid_reg;
        dout_loaded_next = dout_loaded_reg;
        cmd_err_next     = 1'b0;

        if (bus.rx_valid) begin
            // Any strobe ends the current tx_valid hold; a valid read
            // re-asserts it below.
            tx_valid_next = 1'b0;
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr_next = payload[ADDR_SIZE-1:0];
                    wa_ok_next   = 1'b1;
                end
                CMD_WR_DATA: begin
                    if (!wa_ok_reg) begin
                        cmd_err_next = 1'b1;
                    end else if (AUTO_INC != 0) begin
                        // ADDR_SIZE-bit arithmetic wraps at MEM_DEPTH.
                        wr_addr_next = wr_addr_reg + ADDR_ONE;
                    end
                end
                CMD_RD_ADDR: begin
                    rd_addr_next = payload[ADDR_SIZE-1:0];
                    state_next   = RD_ARMED;
                end
                default: begin // CMD_RD_DATA
                    if (state_reg != RD_ARMED) begin
                        cmd_err_next = 1'b1;
                    end else begin
                        tx_valid_next    = 1'b1;
                        dout_loaded_next = 1'b1;
                        if (AUTO_INC != 0) begin
                            rd_addr_next = rd_addr_reg + ADDR_ONE;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_reg     <= '0;
            rd_addr_reg     <= '0;
            wa_ok_reg       <= 1'b0;
            state_reg       <= IDLE;
            tx_valid_reg    <= 1'b0;
            cmd_err_reg     <= 1'b0;
            dout_loaded_reg <= 1'b0;
        end else begin
            wr_addr_reg     <= wr_addr_next;
            rd_addr_reg     <= rd_addr_next;
            wa_ok_reg       <= wa_ok_next;
            state_reg       <= state_next;
            tx_valid_reg    <= tx_valid_next;
            cmd_err_reg     <= cmd_err_next;
            dout_loaded_reg <= dout_loaded_next;
        end
    end

    // RAM write port and registered read port. A write and a read can never
    // hit the same edge (one command per cycle), so a read strobe in the
    // cycle after a write strobe already sees the new data.
    always_ff @(posedge clk) begin
        if (wr_strobe) begin
            mem[wr_addr_reg] <= payload;
        end
        if (rd_strobe) begin
            rd_data_reg <= mem[rd_addr_reg];
        end
    end

    // The read register itself has no reset (keeps block-RAM inference);
    // dout_loaded_reg forces dout to zero from reset until the first read.
    assign bus.dout     = dout_loaded_reg ? rd_data_reg : 8'h00;
    assign bus.tx_valid = tx_valid_reg;
    assign bus.cmd_err  = cmd_err_reg;

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Single-port RAM and command decoder that sits directly downstream of the SPI slave.
- Consumes each 10-bit word the slave delivers (rx_data with an rx_valid pulse).
- Decodes the 2-bit command in bits [9:8] and performs RAM address load, write or read.
- Returns read data to the slave's tx_data/tx_valid inputs so it can be serialised onto MISO.

Parameters:
- MEM_DEPTH, 256, number of 8-bit RAM words; must be a power of two, at most 256.
- ADDR_SIZE, 8, address register width; equals log2(MEM_DEPTH).
- AUTO_INC, 0, when 1 the write and read addresses post-increment after each data access.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset; asynchronous, active-high; clears all registers except the memory array.
- din  input  10  command word from the SPI slave; [9:8]=cmd, [7:0]=payload.
- rx_valid  input  1  one-cycle strobe; din is valid this cycle.
- dout  output  8  read data presented to the SPI slave tx_data.
- tx_valid  output  1  dout is valid; level signal, held as described below.
- cmd_err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset values: dout=0, tx_valid=0, cmd_err=0, wr_addr=0, rd_addr=0, state=IDLE; memory contents are not reset.
- Commands are decoded only in a cycle with rx_valid=1; din is ignored otherwise.
- cmd 00 (write address): wr_addr <= din[ADDR_SIZE-1:0]; set wa_ok.
- cmd 01 (write data):
  - if wa_ok, mem[wr_addr] <= din[7:0] at the next edge;
  - if AUTO_INC=1, wr_addr <= wr_addr+1, wrapping MEM_DEPTH-1 -> 0;
  - if wa_ok=0, no write occurs and cmd_err pulses next cycle.
- cmd 10 (read address): rd_addr <= din[ADDR_SIZE-1:0]; state -> RD_ARMED.
- cmd 11 (read data):
  - if state=RD_ARMED, dout <= mem[rd_addr] and tx_valid <= 1, both one cycle after the rx_valid cycle;
  - state -> IDLE;
  - if AUTO_INC=1, rd_addr increments with wrap and the state stays RD_ARMED;
  - if not RD_ARMED, cmd_err pulses, tx_valid stays 0 and dout is unchanged.
- State machine (read path): IDLE --cmd10--> RD_ARMED --cmd11--> IDLE (or RD_ARMED if AUTO_INC=1).
  - cmd00 and cmd01 do not change the read state.
  - A second cmd10 while RD_ARMED reloads rd_addr.
- tx_valid hold rule:
  - once set, tx_valid and dout hold until the next rx_valid cycle of any command;
  - tx_valid then drops on the following edge, unless that command is itself a valid cmd11, which reloads dout and keeps tx_valid=1.
  - Holding is required because the slave samples tx_valid over 8 later cycles.
- Payload width: din bits above ADDR_SIZE-1 are ignored for address commands; address arithmetic is modulo MEM_DEPTH.
- wa_ok is set by cmd00 and stays set until reset. Write address and read address are independent registers.
- Same-address write-then-read:
  - the read returns the new value when cmd11 arrives at least one cycle after the cmd01 strobe;
  - rx_valid strobes are never back-to-back from the slave, but the RTL must still handle them, writing before reading.
- Asynchronous rst mid-operation immediately clears tx_valid, dout, cmd_err, addresses and state; memory data is retained.
- Total latency from rx_valid to a RAM effect or to tx_valid: 1 clock.

Test Plan:
- Reset, then rx_valid with din=0x005 (wr addr 5) followed by din=0x1A5 (write 0xA5); then din=0x205 and din=0x300 -> tx_valid=1 and dout=0xA5 one cycle after the cmd11 strobe; held until the next strobe.
- After reset, send cmd01 din=0x133 with no prior cmd00 -> cmd_err one-cycle pulse; a later read of mem[0] does not return 0x33.
- After reset, send cmd11 din=0x300 with no cmd10 -> cmd_err pulse, tx_valid stays 0, dout=0.
- AUTO_INC=1: cmd00 addr 0xFF, write 0x11, then write 0x22 (wraps to addr 0); cmd10 addr 0xFF, cmd11 twice -> dout 0x11 then 0x22, tx_valid remaining 1 across both.
- Assert rst asynchronously while tx_valid=1 (mid-read) -> tx_valid=0 and dout=0 with no clock edge; after release, cmd10/cmd11 of the earlier address returns the previously written byte.
- Hold check: after a read, idle 20 cycles with no rx_valid -> tx_valid and dout remain stable; the next cmd00 strobe -> tx_valid=0 on the following edge.
